// File: rtl/npu_arb_pkg.sv
// rtl/npu_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package npu_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Modulo increment that works for any requester count, not just powers of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin scan: first set request at or after start
module rr_picker #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] start,
  output logic            found,
  output logic [ID_W-1:0] pick
);

  int idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-locked sharing of one FIFO write port
module fifo_wr_arbiter
  import npu_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NBITS     = 16,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_val,
  input  logic [NREQ*NBITS-1:0] req_data,
  output logic [NREQ-1:0]       req_rdy,
  output logic                  fifo_wen,
  output logic [NBITS-1:0]      fifo_d,
  input  logic                  fifo_full,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_d;
  logic [ID_W-1:0]  owner, owner_d;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_d;

  logic [ID_W-1:0]  owner_inc;
  logic             idle_found, rep_found;
  logic [ID_W-1:0]  idle_pick, rep_pick;
  logic             beat, burst_end;

  assign owner_inc = ID_W'(rr_next(int'(owner), NREQ));

  rr_picker #(.NREQ(NREQ), .ID_W(ID_W)) u_idle_pick (
    .req   (req_val),
    .start (rr_ptr),
    .found (idle_found),
    .pick  (idle_pick)
  );

  // Burst-end re-pick starts just past the owner so a dropped owner never re-wins.
  rr_picker #(.NREQ(NREQ), .ID_W(ID_W)) u_rep_pick (
    .req   (req_val),
    .start (owner_inc),
    .found (rep_found),
    .pick  (rep_pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      rr_ptr   <= rr_ptr_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    beat_cnt_d = beat_cnt;
    req_rdy    = '0;
    fifo_wen   = 1'b0;
    fifo_d     = '0;
    grant_id   = '0;
    busy       = 1'b0;
    beat       = 1'b0;
    burst_end  = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (idle_found) begin
          state_d    = ARB_GRANT;
          owner_d    = idle_pick;
          beat_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        busy           = 1'b1;
        grant_id       = owner;
        fifo_d         = req_data[int'(owner)*NBITS +: NBITS];
        beat           = req_val[owner] & ~fifo_full;
        fifo_wen       = beat;
        req_rdy[owner] = ~fifo_full;
        burst_end      = (beat && (beat_cnt == LAST_BEAT)) || !req_val[owner];
        if (burst_end) begin
          rr_ptr_d   = owner_inc;
          beat_cnt_d = '0;
          if (rep_found) begin
            owner_d = rep_pick;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - vector-table and scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_val = '0;
  logic [NREQ*NBITS-1:0] req_data = '0;
  logic [NREQ-1:0]       req_rdy;
  logic                  fifo_wen;
  logic [NBITS-1:0]      fifo_d;
  logic                  fifo_full = 1'b0;
  logic [1:0]            grant_id;
  logic                  busy;

  fifo_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .fifo_wen  (fifo_wen),
    .fifo_d    (fifo_d),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] val;
    logic       full;
    logic       wen;
    logic [3:0] rdy;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [11:0] seq[NREQ];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic vec_t mk_idle(input logic r, input logic [3:0] v);
    vec_t t;
    t.rst = r; t.val = v; t.full = 1'b0;
    t.wen = 1'b0; t.rdy = 4'b0; t.gid = 2'd0; t.busy = 1'b0;
    return t;
  endfunction

  function automatic vec_t mk_gnt(input logic [3:0] v, input logic f, input logic [1:0] g);
    vec_t t;
    t.rst = 1'b1; t.val = v; t.full = f;
    t.wen = v[g] & ~f;
    t.rdy = f ? 4'b0000 : (4'b0001 << g);
    t.gid = g; t.busy = 1'b1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t t);
    rst       = t.rst;
    req_val   = t.val;
    fifo_full = t.full;
    for (int i = 0; i < NREQ; i++) req_data[i*NBITS +: NBITS] = {4'(i), seq[i]};
  endtask

  task automatic compare(input vec_t t, input int idx);
    logic [15:0] exp_d;
    chk($sformatf("row%0d fifo_wen", idx), 32'(fifo_wen), 32'(t.wen));
    chk($sformatf("row%0d req_rdy", idx), 32'(req_rdy), 32'(t.rdy));
    chk($sformatf("row%0d grant_id", idx), 32'(grant_id), 32'(t.gid));
    chk($sformatf("row%0d busy", idx), 32'(busy), 32'(t.busy));
    if (!t.busy) chk($sformatf("row%0d fifo_d idle", idx), 32'(fifo_d), 32'd0);
    if (t.wen) begin
      sb.push_back({2'b00, t.gid, seq[t.gid]});
      seq[t.gid] = seq[t.gid] + 12'd1;
    end
    if (fifo_wen) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL row%0d fifo_d: got %0h expected no write", idx, fifo_d);
      end else begin
        exp_d = sb.pop_front();
        chk($sformatf("row%0d fifo_d", idx), 32'(fifo_d), 32'(exp_d));
      end
    end
  endtask

  task automatic apply_row(input vec_t t, input int idx);
    @(posedge clk);
    #1 drive(t);
    @(negedge clk);
    compare(t, idx);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) seq[i] = 12'h100 * 12'(i + 1);
    #1 rst = 1'b0;

    // Reset hold, release, then four full bursts rotating 0,1,2,3,0.
    repeat (3) vecs.push_back(mk_idle(1'b0, 4'b1111));
    vecs.push_back(mk_idle(1'b1, 4'b1111));
    for (int g = 0; g < 4; g++)
      repeat (4) vecs.push_back(mk_gnt(4'b1111, 1'b0, 2'(g)));
    vecs.push_back(mk_gnt(4'b1111, 1'b0, 2'd0));
    vecs.push_back(mk_idle(1'b0, 4'b0000));

    // Lone requester 2: regrant without bubble, drop, idle, next pick starts at 3.
    vecs.push_back(mk_idle(1'b1, 4'b0100));
    repeat (6) vecs.push_back(mk_gnt(4'b0100, 1'b0, 2'd2));
    vecs.push_back(mk_gnt(4'b0000, 1'b0, 2'd2));
    vecs.push_back(mk_idle(1'b1, 4'b0000));
    vecs.push_back(mk_idle(1'b1, 4'b1111));
    vecs.push_back(mk_gnt(4'b1111, 1'b0, 2'd3));
    vecs.push_back(mk_idle(1'b0, 4'b0000));

    // Full stall mid-burst holds the grant and the beat count.
    vecs.push_back(mk_idle(1'b1, 4'b0110));
    repeat (2) vecs.push_back(mk_gnt(4'b0110, 1'b0, 2'd1));
    repeat (3) vecs.push_back(mk_gnt(4'b0110, 1'b1, 2'd1));
    repeat (2) vecs.push_back(mk_gnt(4'b0110, 1'b0, 2'd1));
    vecs.push_back(mk_gnt(4'b0110, 1'b0, 2'd2));
    vecs.push_back(mk_idle(1'b0, 4'b0000));

    // Owner drop hands over to the next valid index after it.
    vecs.push_back(mk_idle(1'b1, 4'b1001));
    repeat (2) vecs.push_back(mk_gnt(4'b1001, 1'b0, 2'd0));
    vecs.push_back(mk_gnt(4'b1000, 1'b0, 2'd0));
    vecs.push_back(mk_gnt(4'b1000, 1'b0, 2'd3));
    vecs.push_back(mk_idle(1'b0, 4'b0000));

    foreach (vecs[i]) apply_row(vecs[i], i);

    // Asynchronous reset between edges while requester 1 owns the port.
    apply_row(mk_idle(1'b1, 4'b1111), 100);
    repeat (4) apply_row(mk_gnt(4'b1111, 1'b0, 2'd0), 101);
    apply_row(mk_gnt(4'b1111, 1'b0, 2'd1), 102);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async fifo_wen", 32'(fifo_wen), 32'd0);
    chk("async req_rdy", 32'(req_rdy), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async grant_id", 32'(grant_id), 32'd0);
    apply_row(mk_idle(1'b0, 4'b1111), 103);
    apply_row(mk_idle(1'b1, 4'b1111), 104);
    apply_row(mk_gnt(4'b1111, 1'b0, 2'd0), 105);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one FIFO instance (DEPTH/NBITS buffer with wen/d/full) between NREQ producers, e.g. PE-row result streams feeding one output buffer.
- Round-robin arbitration with burst locking: the granted producer keeps the port for up to MAX_BURST accepted beats, then priority rotates.
- Sits directly in front of the FIFO; the read side is unaffected.

Parameters:
- NREQ, 4, number of requesters; must be at least 2.
- NBITS, 16, data width; must equal the FIFO NBITS.
- MAX_BURST, 4, maximum beats accepted per grant; must be at least 1.
- ID_W, $clog2(NREQ), width of the grant index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_val  in  NREQ  per-requester valid.
- req_data  in  NREQ*NBITS  requester i data in bits [i*NBITS +: NBITS].
- req_rdy  out  NREQ  per-requester ready; a beat transfers when val & rdy.
- fifo_wen  out  1  FIFO write enable.
- fifo_d  out  NBITS  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- grant_id  out  ID_W  current owner index.
- busy  out  1  high while in GRANT.

Behaviour:
- Registered state:
  - state: IDLE or GRANT.
  - owner, ID_W bits.
  - rr_ptr, ID_W bits: highest-priority index for the next arbitration.
  - beat_cnt: $clog2(MAX_BURST+1) bits.
- Reset (rst=0, asynchronous, no clock edge needed): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
- Outputs are combinational from state, owner and inputs. In IDLE: fifo_wen=0, req_rdy=0, fifo_d=0, grant_id=0, busy=0. All outputs stay at these values for the whole time rst=0.
- Arbitration pick: the first index with req_val set, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
- IDLE: if any req_val is high, the next state is GRANT with owner=pick and beat_cnt=0. A grant therefore becomes visible one cycle after the request.
- GRANT:
  - busy=1, grant_id=owner, fifo_d=req_data[owner].
  - beat = req_val[owner] & ~fifo_full.
  - fifo_wen = beat. req_rdy[owner] = ~fifo_full. All other req_rdy bits are 0.
- Burst end occurs when either:
  - a beat is accepted with beat_cnt==MAX_BURST-1, or
  - req_val[owner]==0 (requester dropped; no beat that cycle).
- On burst end:
  - rr_ptr <= (owner+1) mod NREQ.
  - Re-arbitrate in the same cycle, with priority starting at (owner+1) mod NREQ and using the current req_val. On the drop case the owner's req_val is 0, so it cannot win.
  - If a winner exists: stay in GRANT with owner=winner and beat_cnt=0. There is no bubble.
  - If no request is pending: go to IDLE.
- Otherwise in GRANT: beat_cnt increments on each beat and holds while fifo_full stalls.
- fifo_full high while in GRANT: no write, no rdy, beat_cnt holds, the burst does not end, and the owner keeps the grant until full clears.
- Requester rule: req_data must stay stable while req_val=1 and no transfer has occurred. The arbiter never accepts a beat while full, so the FIFO never sees wen with full.
- Wrap-around: rr_ptr and the scan index wrap modulo NREQ (NREQ need not be a power of 2).
- A request arriving mid-burst waits; the burst in progress is never preempted.

Decomposition:
- Package npu_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_GRANT}.
  - Function rr_next(idx, n) returning (idx+1) mod n.
- Sub-module rr_picker: combinational.
  - Inputs: req vector and start pointer.
  - Outputs: found flag and pick index.
  - Used twice: for the IDLE pick and for the burst-end re-pick (start = owner+1).

Test Plan:
- Reset: rst=0 with req_val=4'b1111 over several edges -> all outputs 0. Release rst -> grant_id=0 and busy=1 on the next cycle, fifo_wen=1.
- Single requester 2 valid for 6 beats, full=0 -> beats written on 6 consecutive cycles, with a regrant to 2 after beat 4 and no bubble. rr_ptr=3 after the first burst. IDLE after beat 6.
- All four requesters valid continuously -> grant order 0,1,2,3,0 at 4 beats each, fifo_wen=1 every cycle from the first grant onward.
- fifo_full=1 for 3 cycles after beat 2 of requester 1 -> fifo_wen=0 and req_rdy=0 for those 3 cycles, grant held. Beats 3 and 4 then complete and the grant passes to requester 2.
- Requester 0 drops req_val after 2 beats while 3 is valid -> no write on the drop cycle. The next cycle grant_id=3 (priority starts at 1, so 3 is the first valid index).
- rst asserted mid-burst between clock edges -> fifo_wen, req_rdy and busy go to 0 immediately. After release, arbitration restarts at index 0.
